lock_code_checker: RTL

// - Keypad code-entry FSM for the digital lock. Sits directly upstream of JK_ff_asyn_rst, which holds the lock state.
// - Collects digits and compares them to a stored code.
// - Drives the flip-flop's j input (unlock pulse) and k input (relock pulse).
// - Counts failed attempts. Enters a timed lockout after MAX_FAIL consecutive failures.

---
 rtl/lock_code_checker_if.sv | 42 ++++
 rtl/lock_code_checker.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lock_code_checker_if.sv
// Keypad-side bundle for lock_code_checker: key strobe/code in, JK pulses and status out.
// The keypad (or a bench) takes the master side; the checker takes the slave side.
interface lock_code_checker_if #(
    parameter int unsigned CODE_LEN = 4,
    parameter int unsigned MAX_FAIL = 3
) ();

    localparam int unsigned DCW = $clog2(CODE_LEN + 1);
    localparam int unsigned FCW = $clog2(MAX_FAIL + 1);

    logic           key_valid;
    logic [3:0]     key_code;
    logic           j_out;
    logic           k_out;
    logic           lockout;
    logic           busy;
    logic [DCW-1:0] digit_cnt;
    logic [FCW-1:0] fail_cnt;

    modport master (
        output key_valid,
        output key_code,
        input  j_out,
        input  k_out,
        input  lockout,
        input  busy,
        input  digit_cnt,
        input  fail_cnt
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output j_out,
        output k_out,
        output lockout,
        output busy,
        output digit_cnt,
        output fail_cnt
    );

endinterface

// File: rtl/lock_code_checker.sv
// Keypad code-entry FSM feeding the JK lock flip-flop.
// Collects digits, compares against CODE, pulses j (unlock) or k (relock),
// counts consecutive failures and enforces a timed lockout after MAX_FAIL.
// The interface instance must use the same CODE_LEN/MAX_FAIL as this module.
module lock_code_checker #(
    parameter int unsigned            CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0]  CODE           = 16'h1234,
    parameter int unsigned            MAX_FAIL       = 3,
    parameter int unsigned            LOCKOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lock_code_checker_if.slave   bus
);

    localparam int unsigned DCW = $clog2(CODE_LEN + 1);
    localparam int unsigned FCW = $clog2(MAX_FAIL + 1);
    localparam int unsigned TW  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [DCW-1:0] LP_LEN   = DCW'(CODE_LEN);
    localparam logic [FCW-1:0] LP_MAXF  = FCW'(MAX_FAIL);
    localparam logic [TW-1:0]  LP_TLOAD = TW'(LOCKOUT_CYCLES - 1);

    localparam logic [3:0] K_MAX_DIGIT = 4'h9;
    localparam logic [3:0] K_CLEAR     = 4'hA;
    localparam logic [3:0] K_LOCK      = 4'hB;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ENTRY   = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_LOCKOUT = 2'd3;

    logic [1:0]     r_state;
    logic [DCW-1:0] r_digit_cnt;
    logic [FCW-1:0] r_fail_cnt;
    logic [TW-1:0]  r_timer;
    logic           r_match;
    logic           r_j;
    logic           r_k;
    logic           r_lockout;
    logic           r_busy;

    logic [1:0]     w_state_nxt;
    logic [DCW-1:0] w_digit_cnt_nxt;
    logic [DCW-1:0] w_digit_cnt_inc;
    logic [FCW-1:0] w_fail_cnt_nxt;
    logic [FCW-1:0] w_fail_cnt_inc;
    logic [TW-1:0]  w_timer_nxt;
    logic           w_match_nxt;
    logic           w_j_nxt;
    logic           w_k_nxt;
    logic [3:0]     w_exp_digit;
    logic           w_is_digit;

    // Expected digit for the position about to be entered (index = digits accepted so far)
    always_comb begin
        w_exp_digit = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (r_digit_cnt == DCW'(i)) begin
                w_exp_digit = CODE[4*(CODE_LEN-1-i) +: 4];
            end
        end
    end

    assign w_is_digit      = (bus.key_code <= K_MAX_DIGIT);
    assign w_digit_cnt_inc = r_digit_cnt + 1'b1;
    assign w_fail_cnt_inc  = (r_fail_cnt == LP_MAXF) ? r_fail_cnt : r_fail_cnt + 1'b1;

    // Next-state and next-output decode; outputs are registered from these values
    always_comb begin
        w_state_nxt     = r_state;
        w_digit_cnt_nxt = r_digit_cnt;
        w_fail_cnt_nxt  = r_fail_cnt;
        w_timer_nxt     = r_timer;
        w_match_nxt     = r_match;
        w_j_nxt         = 1'b0;
        w_k_nxt         = 1'b0;

        case (r_state)
            S_IDLE, S_ENTRY: begin
                // match is 1 whenever IDLE is entered, so IDLE and ENTRY share the digit path
                if (bus.key_valid) begin
                    if (w_is_digit) begin
                        w_match_nxt     = r_match & (bus.key_code == w_exp_digit);
                        w_digit_cnt_nxt = w_digit_cnt_inc;
                        w_state_nxt     = (w_digit_cnt_inc == LP_LEN) ? S_CHECK : S_ENTRY;
                    end else if (bus.key_code == K_CLEAR) begin
                        w_digit_cnt_nxt = '0;
                        w_match_nxt     = 1'b1;
                        w_state_nxt     = S_IDLE;
                    end else if (bus.key_code == K_LOCK) begin
                        w_k_nxt         = 1'b1;
                        w_digit_cnt_nxt = '0;
                        w_match_nxt     = 1'b1;
                        w_state_nxt     = S_IDLE;
                    end
                end
            end

            S_CHECK: begin
                w_digit_cnt_nxt = '0;
                w_match_nxt     = 1'b1;
                if (r_match) begin
                    w_j_nxt        = 1'b1;
                    w_fail_cnt_nxt = '0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_k_nxt        = 1'b1;
                    w_fail_cnt_nxt = w_fail_cnt_inc;
                    if (w_fail_cnt_inc == LP_MAXF) begin
                        w_state_nxt = S_LOCKOUT;
                        w_timer_nxt = LP_TLOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_fail_cnt_nxt = '0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_digit_cnt_nxt = '0;
                w_match_nxt     = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_digit_cnt <= '0;
            r_fail_cnt  <= '0;
            r_timer     <= '0;
            r_match     <= 1'b1;
            r_j         <= 1'b0;
            r_k         <= 1'b0;
            r_lockout   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_digit_cnt <= w_digit_cnt_nxt;
            r_fail_cnt  <= w_fail_cnt_nxt;
            r_timer     <= w_timer_nxt;
            r_match     <= w_match_nxt;
            r_j         <= w_j_nxt;
            r_k         <= w_k_nxt;
            r_lockout   <= (w_state_nxt == S_LOCKOUT);
            r_busy      <= (w_state_nxt == S_CHECK) || (w_state_nxt == S_LOCKOUT);
        end
    end

    assign bus.j_out     = r_j;
    assign bus.k_out     = r_k;
    assign bus.lockout   = r_lockout;
    assign bus.busy      = r_busy;
    assign bus.digit_cnt = r_digit_cnt;
    assign bus.fail_cnt  = r_fail_cnt;

endmodule
